// File: rtl/flash_stream_reader_if.sv
// Command, stream and flash-pin bundle for the SPI-flash read engine.
// slave = the engine itself, master = the boot controller / flash side.
interface flash_stream_reader_if #(
    parameter int LEN_W = 16
);
    logic             i_start;
    logic [23:0]      i_flash_addr;
    logic [LEN_W-1:0] i_length;
    logic             o_busy;
    logic             o_done;
    logic [7:0]       o_data_out;
    logic             o_data_valid;
    logic             i_data_ready;
    logic             o_flash_cs_n;
    logic             o_flash_clk;
    logic             o_flash_di;
    logic             i_flash_do;

    modport slave (
        input  i_start, i_flash_addr, i_length, i_data_ready, i_flash_do,
        output o_busy, o_done, o_data_out, o_data_valid,
               o_flash_cs_n, o_flash_clk, o_flash_di
    );

    modport master (
        output i_start, i_flash_addr, i_length, i_data_ready, i_flash_do,
        input  o_busy, o_done, o_data_out, o_data_valid,
               o_flash_cs_n, o_flash_clk, o_flash_di
    );
endinterface

// File: rtl/flash_stream_reader.sv
// Autonomous SPI-flash READ (0x03) engine: sends command+address, then streams
// bytes out over valid/ready, pausing flash_clk while a byte waits for acceptance.
module flash_stream_reader #(
    parameter int CLKDIV = 1,
    parameter int LEN_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    flash_stream_reader_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SHIFT_HDR, SHIFT_DATA, WAIT_ACK, DESELECT} state_t;

    localparam logic [7:0]       DIV_M1  = 8'(CLKDIV - 1);
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_t           r_state, w_next;
    logic [7:0]       r_div;
    logic             r_clk;
    logic [4:0]       r_bit;
    logic [31:0]      r_sr;
    logic [6:0]       r_rx;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_done;
    logic [LEN_W-1:0] r_cnt;

    logic w_tick, w_fall, w_acc, w_last_bit;

    assign w_tick     = (r_div == 8'd0);
    assign w_fall     = w_tick & r_clk;
    assign w_acc      = r_valid & bus.i_data_ready;
    assign w_last_bit = (r_state == SHIFT_HDR) ? (r_bit == 5'd31) : (r_bit == 5'd7);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_div   <= 8'd0;
            r_clk   <= 1'b0;
            r_bit   <= 5'd0;
            r_sr    <= 32'd0;
            r_rx    <= 7'd0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_length != '0) begin
                            r_sr  <= {8'h03, bus.i_flash_addr};
                            r_cnt <= bus.i_length;
                            r_div <= DIV_M1;
                            r_clk <= 1'b0;
                            r_bit <= 5'd0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                SHIFT_HDR, SHIFT_DATA: begin
                    if (w_tick) begin
                        r_div <= DIV_M1;
                        r_clk <= ~r_clk;
                        // falling edge: sample MISO and present the next MOSI bit
                        if (r_clk) begin
                            r_sr  <= {r_sr[30:0], 1'b0};
                            r_rx  <= {r_rx[5:0], bus.i_flash_do};
                            r_bit <= w_last_bit ? 5'd0 : r_bit + 5'd1;
                            if (r_state == SHIFT_DATA && w_last_bit) begin
                                r_data  <= {r_rx, bus.i_flash_do};
                                r_valid <= 1'b1;
                            end
                        end
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                WAIT_ACK: begin
                    if (w_acc) begin
                        r_valid <= 1'b0;
                        r_cnt   <= r_cnt - CNT_ONE;
                        r_div   <= DIV_M1;
                    end
                end
                DESELECT: begin
                    if (w_tick) r_done <= 1'b1;
                    else        r_div  <= r_div - 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (bus.i_start && bus.i_length != '0) w_next = SHIFT_HDR;
            SHIFT_HDR:  if (w_fall && w_last_bit) w_next = SHIFT_DATA;
            SHIFT_DATA: if (w_fall && w_last_bit) w_next = WAIT_ACK;
            WAIT_ACK:   if (w_acc) w_next = (r_cnt == CNT_ONE) ? DESELECT : SHIFT_DATA;
            DESELECT:   if (w_tick) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_busy       = (r_state != IDLE);
        bus.o_flash_cs_n = (r_state == IDLE) || (r_state == DESELECT);
        bus.o_flash_clk  = r_clk;
        bus.o_flash_di   = (r_state == SHIFT_HDR) & r_sr[31];
        bus.o_done       = r_done;
        bus.o_data_out   = r_data;
        bus.o_data_valid = r_valid;
    end
endmodule

// File: tb/tb_flash_stream_reader.sv
// Runs the reader at D=1 and D=2 side by side on shared stimulus; each lane has a
// flash model and an event-timing scoreboard derived from the transfer rules.
module tb_flash_stream_reader;
    localparam int LW = 6;

    logic            clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
    logic [23:0]     s_addr = 24'd0;
    logic [LW-1:0]   s_len = '0;
    int              cyc = 0, total = 0, bad = 0, rmode = 0, t0 = 0;
    logic [7:0]      fb [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // rmode: 0 = ready tied high, 1 = random ready, 2 = ready held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       ready = 1'b1;
            1:       ready = 1'($urandom_range(0, 1));
            default: ready = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int D = g + 1;
        flash_stream_reader_if #(.LEN_W(LW)) bus();
        flash_stream_reader #(.CLKDIV(D), .LEN_W(LW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
        assign bus.i_start      = start;
        assign bus.i_flash_addr = s_addr;
        assign bus.i_length     = s_len;
        assign bus.i_data_ready = ready;

        int rises = 0, m_start = 0, m_len = 0, nbyte = 0, last_acc = 0;
        int cs_cnt = 0, busy_cnt = 0, first_rel = 0, done_rel = 0;
        logic [31:0] hdr = 32'd0;
        logic [23:0] m_addr = 24'd0;
        logic [7:0]  pd = 8'd0, fbyte;
        bit active = 0, got_done = 0, pv = 0, pr = 0, pck = 0;
        logic fdo;

        // flash: after 32 header clocks, stream bit s of fb[] during the (33+s)th clock high
        always @* begin
            fdo = 1'b0;
            fbyte = 8'h00;
            if (rises >= 33) begin
                fbyte = fb[((rises - 33) / 8) % 64];
                fdo = fbyte[7 - ((rises - 33) % 8)];
            end
        end
        assign bus.i_flash_do = fdo;

        always @(negedge clk) begin
            if (rst) begin
                active = 0;
                pv = 0;
                pck = 0;
            end else begin
                if (!bus.o_flash_cs_n && bus.o_flash_clk && !pck) begin
                    if (rises < 32) hdr = {hdr[30:0], bus.o_flash_di};
                    rises++;
                end
                pck = bus.o_flash_clk;
                if (active && !bus.o_flash_cs_n) cs_cnt++;
                if (active && bus.o_busy) busy_cnt++;
                if (bus.o_data_valid) begin
                    chk("valid_active", 64'(active), 64'd1);
                    chk("wait_pins", {bus.o_flash_cs_n, bus.o_flash_clk}, 2'b00);
                    if (pv && !pr) chk("hold_data", bus.o_data_out, pd);
                    if (!pv) begin
                        chk("valid_cycle", cyc, (nbyte == 0) ? m_start + 1 + 80 * D : last_acc + 16 * D + 1);
                        chk("byte", bus.o_data_out, fb[nbyte % 64]);
                        if (nbyte == 0) first_rel = cyc - m_start;
                    end
                    if (ready) begin
                        last_acc = cyc;
                        nbyte++;
                    end
                end
                if (bus.o_done) begin
                    chk("done_active", 64'(active), 64'd1);
                    if (active) begin
                        chk("done_cycle", cyc, (m_len == 0) ? m_start + 1 : last_acc + D + 1);
                        chk("byte_count", nbyte, m_len);
                        chk("cs_low_cycles", cs_cnt, (m_len == 0) ? 0 : last_acc - m_start);
                        chk("busy_cycles", busy_cnt, cyc - m_start - 1);
                        if (m_len != 0) begin
                            chk("header", hdr, {8'h03, m_addr});
                            chk("clk_rises", rises, 32 + 8 * m_len);
                        end
                        done_rel = cyc - m_start;
                        got_done = 1;
                        active = 0;
                    end
                end
                if (start && !bus.o_busy) begin
                    active = 1; got_done = 0; m_start = cyc; m_len = int'(s_len); m_addr = s_addr;
                    nbyte = 0; cs_cnt = 0; busy_cnt = 0; rises = 0; hdr = 32'd0;
                end
                pv = bus.o_data_valid;
                pr = ready;
                pd = bus.o_data_out;
            end
        end
    end

    task automatic quiet(input string tag, input int g);
        logic [13:0] v;
        if (g == 0) v = {gi[0].bus.o_flash_cs_n, gi[0].bus.o_flash_clk, gi[0].bus.o_flash_di, gi[0].bus.o_busy,
                         gi[0].bus.o_done, gi[0].bus.o_data_valid, gi[0].bus.o_data_out};
        else        v = {gi[1].bus.o_flash_cs_n, gi[1].bus.o_flash_clk, gi[1].bus.o_flash_di, gi[1].bus.o_busy,
                         gi[1].bus.o_done, gi[1].bus.o_data_valid, gi[1].bus.o_data_out};
        chk(tag, v, 14'h2000);
    endtask

    task automatic pulse_start(input logic [23:0] a, input int n);
        @(posedge clk); #1;
        s_addr = a;
        s_len = LW'(n);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!(gi[0].got_done && gi[1].got_done) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("finished_in_budget", 64'(gi[0].got_done && gi[1].got_done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_fb();
        for (int i = 0; i < 64; i++) fb[i] = 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_fb();
        repeat (3) @(posedge clk);
        @(negedge clk);
        quiet("reset_d1", 0);
        quiet("reset_d2", 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic single byte
        fb[0] = 8'hC3;
        rmode = 0;
        pulse_start(24'h05A000, 1);
        wait_done(400);
        chk("t1_valid_d1", gi[0].first_rel, 81);
        chk("t1_done_d1", gi[0].done_rel, 83);
        chk("t1_valid_d2", gi[1].first_rel, 161);
        chk("t1_done_d2", gi[1].done_rel, 164);

        // two bytes back to back
        fb[0] = 8'h12;
        fb[1] = 8'h34;
        pulse_start(24'($urandom), 2);
        wait_done(400);
        chk("t2_done_d1", gi[0].done_rel, 100);
        chk("t2_rises_d1", gi[0].rises, 48);
        chk("t2_done_d2", gi[1].done_rel, 197);

        // backpressure: ready low until cycle 171
        fill_fb();
        rmode = 2;
        pulse_start(24'($urandom), 1);
        while (cyc < t0 + 170) @(negedge clk);
        rmode = 0;
        wait_done(400);
        chk("t3_valid_d2", gi[1].first_rel, 161);
        chk("t3_done_d2", gi[1].done_rel, 174);
        chk("t3_done_d1", gi[0].done_rel, 173);

        // zero length
        pulse_start(24'($urandom), 0);
        wait_done(20);
        chk("t4_done_d1", gi[0].done_rel, 1);
        chk("t4_done_d2", gi[1].done_rel, 1);

        // reset in the address phase, then a fresh transfer
        pulse_start(24'($urandom), 3);
        while (cyc < t0 + 20) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        quiet("midrst_d1", 0);
        quiet("midrst_d2", 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        fill_fb();
        rmode = 1;
        pulse_start(24'($urandom), 2);
        wait_done(1000);

        // second start during a transfer must be ignored
        fill_fb();
        rmode = 0;
        pulse_start(24'h3C5A96, 2);
        while (cyc < t0 + 10) begin
            @(posedge clk); #1;
        end
        s_addr = 24'hC3A569;
        s_len = LW'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400);
        chk("t6_bytes_d1", gi[0].nbyte, 2);
        chk("t6_hdr_d2", gi[1].hdr, 32'h033C5A96);

        // random transfers with random backpressure
        for (int t = 0; t < 8; t++) begin
            fill_fb();
            rmode = int'($urandom_range(0, 1));
            pulse_start(24'($urandom), int'($urandom_range(1, 4)));
            wait_done(1200);
        end

        // maximum length the counter can hold
        fill_fb();
        rmode = 0;
        pulse_start(24'($urandom), (1 << LW) - 1);
        wait_done(3000);
        chk("max_len_bytes", gi[1].nbyte, (1 << LW) - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
- Autonomous SPI-flash read engine that runs alongside the CPU-driven SPI port module, on the same flash pins.
- Given a 24-bit start address and byte count, it issues a READ (0x03) command and streams the returned bytes downstream over a valid/ready handshake.
- Used at boot to copy the ROM/core image from flash into SRAM without CPU bit-banging.
- Top level muxes the flash pins between this block (busy=1) and the CPU SPI port module (busy=0).

Parameters:
CLKDIV, 1, flash_clk half-period in clk cycles (D); legal range 1..255.
LEN_W, 16, width of the byte-count input.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; sampled only when busy=0
flash_addr  input  24  start byte address, latched on accepted start
length  input  LEN_W  number of bytes to read, latched on accepted start
busy  output  1  engine active, including the CS-deselect tail
done  output  1  one-cycle pulse at end of transfer
data_out  output  8  received byte, MSB first on wire
data_valid  output  1  data_out valid, held until accepted
data_ready  input  1  downstream accepts when data_valid&&data_ready
flash_cs_n  output  1  flash chip select
flash_clk  output  1  SPI clock, mode 0 (idle low)
flash_di  output  1  MOSI
flash_do  input  1  MISO

Behaviour:
- Reset values: flash_cs_n=1, flash_clk=0, flash_di=0, busy=0, done=0, data_valid=0, data_out=0.
- rst mid-transfer: all of the above restored at the next edge and the engine returns to IDLE; no done pulse.
- States: IDLE, SHIFT_HDR, SHIFT_DATA, WAIT_ACK, DESELECT.
- IDLE: start=1 with length!=0 at cycle 0 → busy=1 at cycle 1, flash_cs_n=0 at cycle 1, enter SHIFT_HDR.
- IDLE: start=1 with length=0 → done pulses at cycle 1; busy stays 0; CS is never asserted.
- start while busy=1: ignored.
- Bit timing, each bit = 2D cycles:
  - Low phase (flash_clk=0) lasts D cycles; flash_di is updated on the edge that starts it.
  - High phase (flash_clk=1) lasts D cycles.
  - flash_do is sampled on the edge that ends the high phase, i.e. the edge that drives flash_clk back to 0.
- SHIFT_HDR: 32 bits, MSB first = {8'h03, flash_addr[23:0]}. Header bit n low phase starts at cycle 1+2nD.
- SHIFT_DATA: 8 bits per byte; flash_di=0.
  - On the sample edge of bit 7 the byte loads data_out and data_valid=1 (T0 = 1+80D for byte 0); enter WAIT_ACK.
- WAIT_ACK: flash_clk held 0, CS held low, data_out/data_valid stable until accepted at edge T.
  - Bytes remain: next byte's low phase starts at T+1. With data_ready tied 1, byte j is valid at T0 + j(16D+1).
  - Last byte accepted at T: data_valid=0 and flash_cs_n=1 at T+1; enter DESELECT.
- DESELECT: CS held high D cycles, then done=1 and busy=0 at T+D+1 → minimum CS-high time D+1 cycles before a new start can assert CS.
- Internal counters:
  - Byte counter is LEN_W bits, decremented on each acceptance.
  - Address is never incremented by the block; the flash auto-increments and wraps at its own top.
- length = 2^LEN_W-1 must complete without counter overflow.
- data_ready asserted while data_valid=0 has no effect.

Test Plan:
- D=1, start with flash_addr=24'h05A000, length=1 → flash_di carries 0x03,0x05,0xA0,0x00 MSB first over cycles 1..64. Flash model returns 0xC3 → data_out=0xC3, data_valid=1 at cycle 81; flash_cs_n=1 at 82; done at 83.
- D=1, length=2, data_ready=1, model bytes 0x12,0x34 → valid at cycles 81 and 98; done at 100; exactly 48 rising flash_clk edges.
- D=2, length=1, data_ready held 0 for 10 cycles after valid → data_valid at 161. flash_clk stays 0, CS stays low and data_out stays stable until acceptance; done exactly D+1=3 cycles after acceptance.
- length=0 start → done at cycle 1; flash_cs_n never 0; busy never 1.
- rst asserted mid-address phase (cycle 20) → cycle 21: flash_cs_n=1, flash_clk=0, busy=0, no done. A fresh start then completes normally.
- start pulsed again at cycle 10 during a transfer → ignored; header bits and byte count unchanged.
